mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, memory address width in bits.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 a_req  input  1  CPU port request, held high until a_done.
REQ-005 a_we  input  1  CPU port write (1) / read (0).
REQ-006 a_word  input  1  CPU port size: 1 = 16-bit word, 0 = byte.
REQ-007 a_addr  input  16  CPU port byte address.
REQ-008 a_wdata  input  16  CPU port write data; byte access uses [7:0].
REQ-009 a_rdata  output  16  CPU port read data; byte read zero-extends.
REQ-010 a_done  output  1  one-cycle CPU completion pulse.
REQ-011 b_req, b_we, b_addr[15:0], b_wdata[7:0]  input  DMA/loader port, byte-only, same meanings as port A.
REQ-012 b_rdata  output  8  DMA port read data.
REQ-013 b_done  output  1  one-cycle DMA completion pulse.
REQ-014 mem_addr  output  16  byte-memory address.
REQ-015 mem_din  output  8  byte-memory write data.
REQ-016 mem_read, mem_write  output  1  byte-memory strobes.
REQ-017 mem_dout  input  16  memory read data; only [7:0] used; valid combinationally while mem_read high.

Function
REQ-018 The FSM SHALL have states IDLE, XFER0, XFER1 and DONE.
REQ-019 IDLE: if any req is high, latch the winner's we, word, addr and wdata, then go to XFER0; else stay.
REQ-020 Arbitration: a single request wins; simultaneous requests grant the port not granted last (round-robin); port B is never word-sized.
REQ-021 XFER0: mem_addr = latched addr, mem_din = wdata[7:0]; mem_write = we, mem_read = !we; read captures mem_dout[7:0] into rdata low byte at the cycle-ending edge.
REQ-022 XFER0 next state: XFER1 if word, else DONE.
REQ-023 XFER1: mem_addr = latched addr + 1 modulo 2^16 (0xFFFF wraps to 0x0000), mem_din = wdata[15:8]; a read captures into rdata[15:8].
REQ-024 DONE: assert the granted port's done for exactly one cycle, then go to IDLE; rdata is valid in the DONE cycle.
REQ-025 Latency from the IDLE edge sampling req to done high: 2 cycles for a byte access, 3 cycles for a word access.
REQ-026 Requesters SHALL drop req on the edge ending DONE; req still high in the following IDLE counts as a new request.
REQ-027 Port rdata SHALL hold until that port's next completed read; a byte read clears a_rdata[15:8].
REQ-028 mem_read and mem_write SHALL never be high together; in IDLE and DONE both are 0, mem_addr = 0 and mem_din = 0.
REQ-029 Strobes SHALL decode combinationally from the state register only, never directly from req inputs.
REQ-030 Request inputs changing outside IDLE SHALL be ignored until the next IDLE.

Reset
REQ-031 rst low SHALL force IDLE and last-grant = B (so A wins the first tie), and clear a_rdata, b_rdata, a_done, b_done and all latched request fields to 0.
REQ-032 Reset during XFER0/XFER1 SHALL deassert mem_write/mem_read immediately, abort without done, and leave memory contents untouched beyond any write edge already taken.

Structure
REQ-033 Package srp16_mem_pkg SHALL hold the state encoding, port-id constants (PORT_A = 0, PORT_B = 1) and ADDR_W.
REQ-034 Round-robin grant logic SHALL be a sub-module mem_rr_arbiter (2 requests, last-grant input, grant output); everything else stays in mem_arbiter.

Verification
REQ-035 A word write of 0xBEEF at 0x1000, then a word read at 0x1000 -> memory holds 0x1000 = 0xEF and 0x1001 = 0xBE; a_rdata = 0xBEEF; a_done 3 cycles after grant.
REQ-036 A byte read with a_word = 0 at 0x1001 -> a_rdata = 0x00BE; a_done 2 cycles after grant.
REQ-037 A word write of 0x1234 at 0xFFFF -> 0xFFFF = 0x34 and 0x0000 = 0x12 (address wrap).
REQ-038 a_req and b_req raised together right after reset, both held -> order A, B, A, B; exactly one done per transfer; strobes never both high.
REQ-039 A DMA byte write of 0x5A to 0x0200, then a CPU byte read of 0x0200 -> a_rdata = 0x005A.
REQ-040 rst asserted during XFER1 of a word write -> no done pulse; strobes low in the same cycle; FSM in IDLE; only the low byte was written.

Source files
------------

// File: rtl/srp16_mem_pkg.sv
// -----------------------------------------------------------------------------
// srp16_mem_pkg
// Shared definitions for the two-port byte-memory arbiter:
//   ADDR_W  - default memory address width in bits
//   state_e - arbiter FSM state encoding (IDLE, XFER0, XFER1, DONE)
//   PORT_A  - port id of the CPU port (word or byte accesses)
//   PORT_B  - port id of the DMA/loader port (byte accesses only)
// -----------------------------------------------------------------------------
package srp16_mem_pkg;

    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER0 = 2'd1,
        XFER1 = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mem_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mem_rr_arbiter
// Two-requester round-robin grant logic, purely combinational.
//   req        in   [1:0]  request vector, indexed by port id
//   last_grant in   1      port id that won the previous arbitration
//   gnt_valid  out  1      at least one request is pending
//   gnt_port   out  1      winning port id (meaningful when gnt_valid)
// A lone request always wins; on a tie the port not granted last wins.
// -----------------------------------------------------------------------------
module mem_rr_arbiter
    import srp16_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_port
);

    always_comb begin
        gnt_valid = |req;
        gnt_port  = PORT_A;
        if (req[PORT_A] && req[PORT_B]) begin
            gnt_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
        end else if (req[PORT_B]) begin
            gnt_port = PORT_B;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one byte-wide memory between a CPU port (A, byte or 16-bit word)
// and a DMA/loader port (B, byte only). A word access is split into two
// byte cycles, low byte at addr and high byte at addr+1 (wrapping).
//   clk               in   system clock, rising edge
//   rst               in   asynchronous active-low reset
//   a_req/a_we/a_word in   CPU request, write flag, word-size flag
//   a_addr/a_wdata    in   CPU byte address / write data
//   a_rdata/a_done    out  CPU read data (held) / one-cycle completion
//   b_req/b_we        in   DMA request / write flag
//   b_addr/b_wdata    in   DMA byte address / write byte
//   b_rdata/b_done    out  DMA read byte (held) / one-cycle completion
//   mem_addr/mem_din  out  memory address / write byte
//   mem_read/mem_write out memory strobes
//   mem_dout          in   memory read data, low byte valid while mem_read
// -----------------------------------------------------------------------------
module mem_arbiter
    import srp16_mem_pkg::*;
#(
    parameter int ADDR_W = srp16_mem_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_word,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    output logic [15:0]       a_rdata,
    output logic              a_done,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [15:0]       mem_dout
);

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       a_rdata_q, a_rdata_d;
    logic [7:0]        b_rdata_q, b_rdata_d;

    logic              gnt_valid;
    logic              gnt_port;

    // The memory is byte wide; the upper half of its data bus is ignored.
    logic              unused_dout_hi;
    assign unused_dout_hi = ^mem_dout[15:8];

    mem_rr_arbiter u_rr (
        .req        ({b_req, a_req}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_port   (gnt_port)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            port_q       <= PORT_A;
            last_grant_q <= PORT_B;     // so A wins the first tie
            we_q         <= 1'b0;
            word_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
        end
    end

    // Next-state, request latching, read capture and memory strobes. The
    // strobes depend only on registered state so a reset that clears
    // state_q drops them in the same cycle.
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        word_d       = word_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        a_rdata_d    = a_rdata_q;
        b_rdata_d    = b_rdata_q;
        mem_addr     = '0;
        mem_din      = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    port_d       = gnt_port;
                    last_grant_d = gnt_port;
                    state_d      = XFER0;
                    if (gnt_port == PORT_A) begin
                        we_d    = a_we;
                        word_d  = a_word;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end else begin
                        we_d    = b_we;
                        word_d  = 1'b0;
                        addr_d  = b_addr;
                        wdata_d = {8'h00, b_wdata};
                    end
                end
            end
            XFER0: begin
                mem_addr  = addr_q;
                mem_din   = wdata_q[7:0];
                mem_write = we_q;
                mem_read  = !we_q;
                if (!we_q) begin
                    if (port_q == PORT_A) begin
                        // A byte read zero-extends; a word read overwrites
                        // the high byte in XFER1 anyway.
                        a_rdata_d = {8'h00, mem_dout[7:0]};
                    end else begin
                        b_rdata_d = mem_dout[7:0];
                    end
                end
                state_d = word_q ? XFER1 : DONE;
            end
            XFER1: begin
                // Only port A reaches here (B is never word-sized).
                mem_addr  = addr_q + ADDR_W'(1);
                mem_din   = wdata_q[15:8];
                mem_write = we_q;
                mem_read  = !we_q;
                if (!we_q) begin
                    a_rdata_d[15:8] = mem_dout[7:0];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign a_done  = (state_q == DONE) && (port_q == PORT_A);
    assign b_done  = (state_q == DONE) && (port_q == PORT_B);
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule
